// File: rtl/float_mult_arbiter_pkg.sv
// float_mult_arbiter_pkg
//   Shared constants and types for the float multiply arbiter slice:
//   single-precision width, canonical zero/NaN encodings and a packed
//   view of an IEEE-754 single.
package float_mult_arbiter_pkg;

   localparam int unsigned FP_WIDTH = 32;
   localparam int unsigned FP_EXP_W = 8;
   localparam int unsigned FP_FRAC_W = 23;

   localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0000_0000;
   localparam logic [FP_WIDTH-1:0] FP_QNAN = 32'h7FC0_0000;

   typedef struct packed {
      logic                 sign;
      logic [FP_EXP_W-1:0]  exp;
      logic [FP_FRAC_W-1:0] frac;
   } fp_t;

   // Zero exponent covers both true zero and denormals, which are flushed.
   function automatic logic fp_is_zero(input fp_t f);
      return (f.exp == '0);
   endfunction

   function automatic logic fp_is_inf(input fp_t f);
      return (f.exp == '1) && (f.frac == '0);
   endfunction

   function automatic logic fp_is_nan(input fp_t f);
      return (f.exp == '1) && (f.frac != '0);
   endfunction

endpackage

// File: rtl/float_mult_arbiter_if.sv
// float_mult_arbiter_if
//   Request/result bus of the float multiply arbiter.
//   req_valid/req_a/req_b : per-requester operand pairs (32 bits each, packed)
//   req_ready             : one-hot grant back to the requesters
//   res_valid/res_ready   : result handshake, res_id/res_product payload
//   op_count              : wrapping count of accepted operations
//   master : requester/consumer side, slave : arbiter side
interface float_mult_arbiter_if
   import float_mult_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDW     = 2
);

   logic [NUM_REQ-1:0]          req_valid;
   logic [FP_WIDTH*NUM_REQ-1:0] req_a;
   logic [FP_WIDTH*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]          req_ready;
   logic                        res_valid;
   logic                        res_ready;
   logic [IDW-1:0]              res_id;
   logic [FP_WIDTH-1:0]         res_product;
   logic [15:0]                 op_count;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_id, res_product, op_count
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_id, res_product, op_count
   );

endinterface

// File: rtl/float_mult_arbiter_fmul.sv
// floatMult
//   Combinational IEEE-754 single-precision multiplier.
//   a_i, b_i : operands
//   p_o      : product, round-to-nearest-even; denormal inputs and
//              underflowing results flush to +0, overflow gives infinity,
//              NaN or inf*0 gives the canonical quiet NaN.
module floatMult
   import float_mult_arbiter_pkg::*;
(
   input  logic [FP_WIDTH-1:0] a_i,
   input  logic [FP_WIDTH-1:0] b_i,
   output logic [FP_WIDTH-1:0] p_o
);

   fp_t                a;
   fp_t                b;
   logic               sign;
   logic [47:0]        prod;
   logic [22:0]        frac;
   logic               guard;
   logic               sticky;
   logic               rnd;
   logic [23:0]        frac_r;
   logic signed [10:0] exp_s;

   assign a = fp_t'(a_i);
   assign b = fp_t'(b_i);

   always_comb begin
      sign = a.sign ^ b.sign;
      prod = {24'b0, 1'b1, a.frac} * {24'b0, 1'b1, b.frac};

      // Product of two 1.x mantissas lies in [1,4); normalise on bit 47.
      if (prod[47]) begin
         frac   = prod[46:24];
         guard  = prod[23];
         sticky = |prod[22:0];
         exp_s  = $signed({3'b0, a.exp}) + $signed({3'b0, b.exp}) - 11'sd126;
      end else begin
         frac   = prod[45:23];
         guard  = prod[22];
         sticky = |prod[21:0];
         exp_s  = $signed({3'b0, a.exp}) + $signed({3'b0, b.exp}) - 11'sd127;
      end

      rnd    = guard & (sticky | frac[0]);
      frac_r = {1'b0, frac} + {23'b0, rnd};
      // Rounding carry-out leaves frac_r[22:0] at zero, only bump exponent.
      if (frac_r[23]) begin
         exp_s = exp_s + 11'sd1;
      end

      if (fp_is_nan(a) || fp_is_nan(b) ||
          (fp_is_inf(a) && fp_is_zero(b)) || (fp_is_inf(b) && fp_is_zero(a))) begin
         p_o = FP_QNAN;
      end else if (fp_is_inf(a) || fp_is_inf(b)) begin
         p_o = {sign, 8'hFF, 23'b0};
      end else if (fp_is_zero(a) || fp_is_zero(b)) begin
         p_o = FP_ZERO;
      end else if (exp_s >= 11'sd255) begin
         p_o = {sign, 8'hFF, 23'b0};
      end else if (exp_s <= 11'sd0) begin
         p_o = FP_ZERO;
      end else begin
         p_o = {sign, exp_s[7:0], frac_r[22:0]};
      end
   end

endmodule

// File: rtl/float_mult_arbiter.sv
// float_mult_arbiter
//   Round-robin arbiter feeding one shared single-precision multiplier
//   whose product lands in a one-entry result register.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : float_mult_arbiter_if slave (requests, grant, result, op_count)
module float_mult_arbiter
   import float_mult_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDW     = 2
)(
   input logic                 clk,
   input logic                 reset,
   float_mult_arbiter_if.slave bus
);

   logic                res_valid_q, res_valid_d;
   logic [IDW-1:0]      res_id_q, res_id_d;
   logic [FP_WIDTH-1:0] res_product_q, res_product_d;
   logic [15:0]         op_count_q, op_count_d;
   logic [IDW-1:0]      last_grant_q, last_grant_d;

   logic                slot_free;
   logic                grant_any;
   logic [IDW-1:0]      grant_idx;
   logic [IDW-1:0]      cand;
   logic [NUM_REQ-1:0]  grant;
   logic [FP_WIDTH-1:0] sel_a;
   logic [FP_WIDTH-1:0] sel_b;
   logic [FP_WIDTH-1:0] product;

   // Grant search starts one past the last winner and wraps; it looks only
   // at req_valid and slot state, never at operand data.
   always_comb begin
      slot_free = !res_valid_q || bus.res_ready;
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      grant     = '0;
      if (reset && slot_free) begin
         for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((32'(last_grant_q) + k) % NUM_REQ);
            if (!grant_any && bus.req_valid[cand]) begin
               grant_any   = 1'b1;
               grant_idx   = cand;
               grant[cand] = 1'b1;
            end
         end
      end
   end

   assign sel_a = bus.req_a[FP_WIDTH*grant_idx +: FP_WIDTH];
   assign sel_b = bus.req_b[FP_WIDTH*grant_idx +: FP_WIDTH];

   floatMult u_fmul (
      .a_i (sel_a),
      .b_i (sel_b),
      .p_o (product)
   );

   always_comb begin
      res_valid_d   = res_valid_q;
      res_id_d      = res_id_q;
      res_product_d = res_product_q;
      op_count_d    = op_count_q;
      last_grant_d  = last_grant_q;
      if (grant_any) begin
         res_valid_d   = 1'b1;
         res_id_d      = grant_idx;
         res_product_d = product;
         op_count_d    = op_count_q + 16'd1;
         last_grant_d  = grant_idx;
      end else if (slot_free) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_valid_q   <= 1'b0;
         res_id_q      <= '0;
         res_product_q <= FP_ZERO;
         op_count_q    <= '0;
         last_grant_q  <= IDW'(NUM_REQ - 1);
      end else begin
         res_valid_q   <= res_valid_d;
         res_id_q      <= res_id_d;
         res_product_q <= res_product_d;
         op_count_q    <= op_count_d;
         last_grant_q  <= last_grant_d;
      end
   end

   assign bus.req_ready   = grant;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_id      = res_id_q;
   assign bus.res_product = res_product_q;
   assign bus.op_count    = op_count_q;

endmodule

// File: tb/tb_float_mult_arbiter.sv
// tb_float_mult_arbiter
//   Directed bench for float_mult_arbiter: reset values, single request,
//   zero operand, round-robin rotation, backpressure, drain, async reset
//   mid-flight and op_count wrap.
module tb_float_mult_arbiter;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   logic [31:0] op_a [4];
   logic [31:0] op_b [4];
   logic [31:0] op_p [4];

   float_mult_arbiter_if #(.NUM_REQ(4), .IDW(2)) bus ();

   float_mult_arbiter #(.NUM_REQ(4), .IDW(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      // req0: 2.0*3.0, req1: 1.0*1.0, req2: x*0, req3: 1.5*-2.0
      op_a[0] = 32'h4000_0000; op_b[0] = 32'h4040_0000; op_p[0] = 32'h40C0_0000;
      op_a[1] = 32'h3F80_0000; op_b[1] = 32'h3F80_0000; op_p[1] = 32'h3F80_0000;
      op_a[2] = 32'h39D8_44D0; op_b[2] = 32'h0000_0000; op_p[2] = 32'h0000_0000;
      op_a[3] = 32'h3FC0_0000; op_b[3] = 32'hC000_0000; op_p[3] = 32'hC040_0000;

      reset         = 1'b0;
      bus.req_valid = 4'h0;
      bus.req_a     = {op_a[3], op_a[2], op_a[1], op_a[0]};
      bus.req_b     = {op_b[3], op_b[2], op_b[1], op_b[0]};
      bus.res_ready = 1'b0;

      // Reset values and no grant during reset
      #6;
      chk("rst_valid",   32'(bus.res_valid),   32'h0);
      chk("rst_id",      32'(bus.res_id),      32'h0);
      chk("rst_product", bus.res_product,      32'h0);
      chk("rst_count",   32'(bus.op_count),    32'h0);
      bus.req_valid = 4'hF;
      #1;
      chk("rst_ready",   32'(bus.req_ready),   32'h0);
      bus.req_valid = 4'h0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // Single requester, same-cycle grant, one-cycle latency
      bus.req_valid = 4'h1;
      bus.res_ready = 1'b1;
      #1;
      chk("single_ready", 32'(bus.req_ready), 32'h1);
      @(posedge clk); #1;
      bus.req_valid = 4'h0;
      chk("single_valid",   32'(bus.res_valid), 32'h1);
      chk("single_id",      32'(bus.res_id),    32'h0);
      chk("single_product", bus.res_product,    32'h40C0_0000);
      chk("single_count",   32'(bus.op_count),  32'h1);

      // Zero operand from requester 2
      bus.req_valid = 4'h4;
      #1;
      chk("zero_ready", 32'(bus.req_ready), 32'h4);
      @(posedge clk); #1;
      bus.req_valid = 4'h0;
      chk("zero_id",      32'(bus.res_id), 32'h2);
      chk("zero_product", bus.res_product, 32'h0);

      // Requester 3 alone: 1.5 * -2.0, leaves last_grant at 3
      bus.req_valid = 4'h8;
      #1;
      chk("r3_ready", 32'(bus.req_ready), 32'h8);
      @(posedge clk); #1;
      chk("r3_id",      32'(bus.res_id), 32'h3);
      chk("r3_product", bus.res_product, 32'hC040_0000);

      // All requesters valid: rotation 0,1,2,3,0,1,2,3 back-to-back
      bus.req_valid = 4'hF;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("rr_ready_%0d", k), 32'(bus.req_ready), 32'(4'h1 << (k % 4)));
         @(posedge clk); #1;
         chk($sformatf("rr_valid_%0d", k),   32'(bus.res_valid), 32'h1);
         chk($sformatf("rr_id_%0d", k),      32'(bus.res_id),    32'(k % 4));
         chk($sformatf("rr_product_%0d", k), bus.res_product,    op_p[k % 4]);
      end
      chk("rr_count", 32'(bus.op_count), 32'd11);

      // Backpressure: id 3 result held, req1 waits
      bus.req_valid = 4'h2;
      bus.res_ready = 1'b0;
      #1;
      chk("bp_ready0", 32'(bus.req_ready), 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("bp_valid_%0d", k),   32'(bus.res_valid), 32'h1);
         chk($sformatf("bp_id_%0d", k),      32'(bus.res_id),    32'h3);
         chk($sformatf("bp_product_%0d", k), bus.res_product,    32'hC040_0000);
         chk($sformatf("bp_ready_%0d", k),   32'(bus.req_ready), 32'h0);
      end
      bus.res_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.req_ready), 32'h2);
      @(posedge clk); #1;
      bus.req_valid = 4'h0;
      chk("bp_id",      32'(bus.res_id),   32'h1);
      chk("bp_product", bus.res_product,   32'h3F80_0000);
      chk("bp_count",   32'(bus.op_count), 32'd12);

      // Drain with no requests; last_grant stays at 1 so next search hits 2
      @(posedge clk); #1;
      chk("drain_valid", 32'(bus.res_valid), 32'h0);
      bus.req_valid = 4'hF;
      #1;
      chk("drain_next_ready", 32'(bus.req_ready), 32'h4);
      @(posedge clk); #1;
      chk("drain_next_id",    32'(bus.res_id),    32'h2);
      chk("drain_next_count", 32'(bus.op_count),  32'd13);

      // Asynchronous reset between edges with a result pending
      bus.req_valid = 4'h0;
      bus.res_ready = 1'b0;
      #2;
      reset = 1'b0;
      bus.req_valid = 4'hF;
      #1;
      chk("mid_valid",   32'(bus.res_valid), 32'h0);
      chk("mid_count",   32'(bus.op_count),  32'h0);
      chk("mid_id",      32'(bus.res_id),    32'h0);
      chk("mid_product", bus.res_product,    32'h0);
      chk("mid_ready",   32'(bus.req_ready), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      bus.res_ready = 1'b1;
      #1;
      chk("post_rst_ready", 32'(bus.req_ready), 32'h1);
      chk("post_rst_valid", 32'(bus.res_valid), 32'h0);
      @(posedge clk); #1;
      chk("post_rst_id",    32'(bus.res_id),    32'h0);
      chk("post_rst_count", 32'(bus.op_count),  32'h1);

      // op_count wrap: requester 0 alone, one transfer per edge
      bus.req_valid = 4'h1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      reset = 1'b1;
      chk("wrap_start", 32'(bus.op_count), 32'h0);
      repeat (65535) @(posedge clk);
      #1;
      chk("wrap_ffff", 32'(bus.op_count), 32'hFFFF);
      @(posedge clk); #1;
      chk("wrap_zero",  32'(bus.op_count),  32'h0);
      chk("wrap_valid", 32'(bus.res_valid), 32'h1);
      bus.req_valid = 4'h0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
